// File: rtl/button_event_decoder.sv
// Per-channel button event decoder: turns debounced levels into press, release,
// long-press and auto-repeat pulses using one shared prescaler tick.
module button_event_decoder #(
    parameter int WIDTH          = 1,
    parameter int TICK_CNT_MAX   = 125000,
    parameter int LONG_TICKS     = 500,
    parameter int REPEAT_TICKS   = 100,
    parameter int TICK_CNT_WIDTH = $clog2(TICK_CNT_MAX),
    parameter int HOLD_CNT_WIDTH = $clog2(LONG_TICKS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_pulse,
    output logic [WIDTH-1:0] repeat_pulse,
    output logic [WIDTH-1:0] held
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    localparam logic [TICK_CNT_WIDTH-1:0] TICK_LAST   = TICK_CNT_WIDTH'(TICK_CNT_MAX - 1);
    localparam logic [HOLD_CNT_WIDTH-1:0] LONG_LAST   = HOLD_CNT_WIDTH'(LONG_TICKS - 1);
    localparam logic [HOLD_CNT_WIDTH-1:0] REPEAT_LAST = HOLD_CNT_WIDTH'(REPEAT_TICKS - 1);

    logic [TICK_CNT_WIDTH-1:0] tick_cnt_r;
    logic                      tick_r;

    // Shared prescaler: tick_r is high for the cycle after the counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= '0;
            tick_r     <= 1'b0;
        end else if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_r <= '0;
            tick_r     <= 1'b1;
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_CNT_WIDTH'(1);
            tick_r     <= 1'b0;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_t                    state_r, state_s;
        logic [HOLD_CNT_WIDTH-1:0] hcnt_r, hcnt_s;
        logic                      press_s, release_s, long_s, repeat_s;
        logic                      press_r, release_r, long_r, repeat_r, held_r;

        // Next-state and pulse decode; release always wins over a same-cycle tick.
        always_comb begin
            state_s   = state_r;
            hcnt_s    = hcnt_r;
            press_s   = 1'b0;
            release_s = 1'b0;
            long_s    = 1'b0;
            repeat_s  = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (debounced_signal[i]) begin
                        state_s = ST_PRESSED;
                        hcnt_s  = '0;
                        press_s = 1'b1;
                    end else begin
                        hcnt_s = '0;
                    end
                end
                ST_PRESSED: begin
                    if (!debounced_signal[i]) begin
                        state_s   = ST_IDLE;
                        hcnt_s    = '0;
                        release_s = 1'b1;
                    end else if (tick_r && (hcnt_r == LONG_LAST)) begin
                        state_s = ST_LONG;
                        hcnt_s  = '0;
                        long_s  = 1'b1;
                    end else if (tick_r) begin
                        hcnt_s = hcnt_r + HOLD_CNT_WIDTH'(1);
                    end else begin
                        hcnt_s = hcnt_r;
                    end
                end
                ST_LONG: begin
                    if (!debounced_signal[i]) begin
                        state_s   = ST_IDLE;
                        hcnt_s    = '0;
                        release_s = 1'b1;
                    end else if (tick_r && (hcnt_r == REPEAT_LAST)) begin
                        hcnt_s   = '0;
                        repeat_s = 1'b1;
                    end else if (tick_r) begin
                        hcnt_s = hcnt_r + HOLD_CNT_WIDTH'(1);
                    end else begin
                        hcnt_s = hcnt_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    hcnt_s  = '0;
                end
            endcase
        end

        // Channel state, hold counter and registered outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r   <= ST_IDLE;
                hcnt_r    <= '0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
                repeat_r  <= 1'b0;
                held_r    <= 1'b0;
            end else begin
                state_r   <= state_s;
                hcnt_r    <= hcnt_s;
                press_r   <= press_s;
                release_r <= release_s;
                long_r    <= long_s;
                repeat_r  <= repeat_s;
                held_r    <= (state_s != ST_IDLE);
            end
        end

        assign press_pulse[i]   = press_r;
        assign release_pulse[i] = release_r;
        assign long_pulse[i]    = long_r;
        assign repeat_pulse[i]  = repeat_r;
        assign held[i]          = held_r;
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder: directed scenarios plus random
// button activity, compared every cycle against an event-level reference model.
module tb_button_event_decoder;

    localparam int W  = 2;
    localparam int T  = 4;
    localparam int L  = 3;
    localparam int R  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic [W-1:0] press_pulse, release_pulse, long_pulse, repeat_pulse, held;

    button_event_decoder #(
        .WIDTH(W), .TICK_CNT_MAX(T), .LONG_TICKS(L), .REPEAT_TICKS(R)
    ) dut (
        .clk(clk), .rst(rst), .debounced_signal(din),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .held(held)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: edges since reset, and per-button hold bookkeeping.
    int           edge_no = 0;
    bit           m_down [W];
    bit           m_long [W];
    int           m_ticks[W];
    logic [W-1:0] e_press, e_release, e_long, e_repeat, e_held;

    int stepn      = 0;
    int last_press = 0;
    int long_cnt   = 0;
    int long_delta = 0;
    int held_cnt   = 0;

    // The prescaler tick is seen by the channels every T edges, first at edge T+1.
    function automatic bit tick_at(input int e);
        return (e >= T + 1) && ((e - 1) % T == 0);
    endfunction

    task automatic model_update(input logic r, input logic [W-1:0] d);
        bit tk;
        e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
        if (r) begin
            edge_no = 0;
            for (int c = 0; c < W; c++) begin
                m_down[c] = 1'b0; m_long[c] = 1'b0; m_ticks[c] = 0;
            end
        end else begin
            edge_no++;
            tk = tick_at(edge_no);
            for (int c = 0; c < W; c++) begin
                if (!m_down[c] && d[c]) begin
                    m_down[c] = 1'b1; m_long[c] = 1'b0; m_ticks[c] = 0;
                    e_press[c] = 1'b1;
                end else if (m_down[c] && !d[c]) begin
                    m_down[c] = 1'b0;
                    e_release[c] = 1'b1;
                end else if (m_down[c] && tk) begin
                    m_ticks[c]++;
                    if (!m_long[c] && m_ticks[c] == L) begin
                        m_long[c] = 1'b1; m_ticks[c] = 0; e_long[c] = 1'b1;
                    end else if (m_long[c] && m_ticks[c] == R) begin
                        m_ticks[c] = 0; e_repeat[c] = 1'b1;
                    end
                end
            end
        end
        for (int c = 0; c < W; c++) e_held[c] = m_down[c];
    endtask

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s step %0d: got %b expected %b", tag, stepn, got, exp);
        end
    endtask

    task automatic chk_true(input string tag, input bit cond, input int got);
        tests++;
        assert (cond) else begin
            fails++;
            $error("FAIL %s step %0d: observed %0d", tag, stepn, got);
        end
    endtask

    task automatic step(input logic r, input logic [W-1:0] d);
        rst = r;
        din = d;
        @(posedge clk);
        model_update(r, d);
        @(negedge clk);
        stepn++;
        chk("press", press_pulse, e_press);
        chk("release", release_pulse, e_release);
        chk("long", long_pulse, e_long);
        chk("repeat", repeat_pulse, e_repeat);
        chk("held", held, e_held);
        if (press_pulse[0]) last_press = stepn;
        if (long_pulse[0]) begin
            long_cnt++;
            long_delta = stepn - last_press;
        end
        if (held[0]) held_cnt++;
    endtask

    initial begin
        int guard;
        logic [W-1:0] rin;

        // Reset held with both buttons down, then the first free edge is a press.
        repeat (3) step(1'b1, 2'b11);
        step(1'b0, 2'b11);
        chk("first_press", press_pulse, 2'b11);
        step(1'b0, 2'b00);
        chk("first_release", release_pulse, 2'b11);
        repeat (3) step(1'b0, 2'b00);

        // Short press of five cycles.
        held_cnt = 0; long_cnt = 0;
        repeat (5) step(1'b0, 2'b01);
        step(1'b0, 2'b00);
        chk_true("short_held_cycles", held_cnt == 5, held_cnt);
        chk_true("short_no_long", long_cnt == 0, long_cnt);
        repeat (3) step(1'b0, 2'b00);

        // Long hold with auto-repeat.
        long_cnt = 0;
        repeat (40) step(1'b0, 2'b01);
        chk_true("long_once", long_cnt == 1, long_cnt);
        chk_true("long_latency", long_delta >= 9 && long_delta <= 13, long_delta);
        step(1'b0, 2'b00);
        repeat (10) step(1'b0, 2'b00);
        chk_true("no_repeat_after_release", repeat_pulse[0] == 1'b0, int'(repeat_pulse[0]));

        // Release exactly on the tick that would have produced long_pulse.
        step(1'b0, 2'b01);
        guard = 0;
        while (!(m_ticks[0] == L - 1 && !m_long[0] && tick_at(edge_no + 1)) && guard < 20) begin
            step(1'b0, 2'b01);
            guard++;
        end
        chk_true("align_bound", guard < 20, guard);
        step(1'b0, 2'b00);
        chk("tick_release", release_pulse, 2'b01);
        chk("tick_no_long", long_pulse, 2'b00);
        repeat (3) step(1'b0, 2'b00);

        // Two channels, second one starting two cycles later.
        repeat (2) step(1'b0, 2'b01);
        repeat (30) step(1'b0, 2'b11);
        step(1'b0, 2'b00);
        chk("both_release", release_pulse, 2'b11);
        repeat (3) step(1'b0, 2'b00);

        // Reset while in the long state, button still down afterwards.
        repeat (15) step(1'b0, 2'b01);
        chk_true("reached_long", m_long[0], int'(m_long[0]));
        step(1'b1, 2'b01);
        chk("rst_held", held, 2'b00);
        chk("rst_no_release", release_pulse, 2'b00);
        step(1'b0, 2'b01);
        chk("post_rst_press", press_pulse, 2'b01);
        step(1'b0, 2'b00);

        // Random activity with long runs and occasional resets.
        rin = '0;
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < W; c++)
                if ($urandom_range(11, 0) == 0) rin[c] = ~rin[c];
            step(($urandom_range(199, 0) == 0) ? 1'b1 : 1'b0, rin);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Per-channel button event decoder placed directly downstream of the input debouncer. It consumes clean, debounced button levels and produces single-cycle event pulses for press, release, long-press and auto-repeat. Application logic such as menus, counters and tempo control consumes these pulses without doing its own edge detection or hold timing. All timing comes from one shared internal prescaler tick, so every channel uses the same time base.

## Interface
Parameters:
- WIDTH, 1: number of independent button channels.
- TICK_CNT_MAX, 125000: prescaler period in clk cycles (1 ms at 125 MHz).
- LONG_TICKS, 500: ticks of continuous hold before long_pulse. Must be ≥ 2.
- REPEAT_TICKS, 100: ticks between repeat_pulse events after a long press. Must satisfy 1 ≤ REPEAT_TICKS ≤ LONG_TICKS.
- TICK_CNT_WIDTH, $clog2(TICK_CNT_MAX): width of the prescaler counter.
- HOLD_CNT_WIDTH, $clog2(LONG_TICKS)+1: width of each per-channel hold counter.

Ports:
- clk, input, 1: single system clock. All logic is on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- debounced_signal, input, WIDTH: debounced button levels (1 = pressed).
- press_pulse, output, WIDTH: one-cycle pulse on press.
- release_pulse, output, WIDTH: one-cycle pulse on release.
- long_pulse, output, WIDTH: one-cycle pulse when the hold reaches LONG_TICKS.
- repeat_pulse, output, WIDTH: one-cycle pulse every REPEAT_TICKS while held past long.
- held, output, WIDTH: level output, 1 while the channel's FSM is not IDLE.

## Operation
Prescaler:
- tick_cnt counts 0..TICK_CNT_MAX-1 and wraps to 0.
- On the edge where tick_cnt == TICK_CNT_MAX-1, the registered signal tick is set to 1 for one cycle. Otherwise tick is 0.

Per-channel FSM, with states IDLE, PRESSED and LONG, and one hold counter hcnt per channel:
- IDLE:
  - If in == 1: go to PRESSED, set hcnt = 0, pulse press_pulse.
- PRESSED:
  - If in == 0: go to IDLE and pulse release_pulse.
  - Else, if tick and hcnt == LONG_TICKS-1: go to LONG, set hcnt = 0, pulse long_pulse.
  - Else, if tick: hcnt++.
- LONG:
  - If in == 0: go to IDLE and pulse release_pulse.
  - Else, if tick and hcnt == REPEAT_TICKS-1: set hcnt = 0 and pulse repeat_pulse.
  - Else, if tick: hcnt++.

Rules:
- Release has priority over tick in the same cycle. No long or repeat pulse is produced on the release cycle.
- hcnt never exceeds LONG_TICKS-1. No arithmetic wraps.
- At most one of the four pulse outputs is asserted per channel per cycle.
- Channels are fully independent. Simultaneous events on different channels all appear in the same cycle.
- held is asserted in PRESSED and LONG.

Reset:
- rst forces all FSMs to IDLE, clears tick_cnt, tick and hcnt, and drives all outputs to 0.
- rst overrides all other activity, including a press in progress. No release_pulse is emitted for a hold interrupted by reset.
- If in == 1 on the first edge after rst deasserts, the channel treats it as a new press and emits press_pulse.

## Timing
- All outputs are registered.
- If in[i] is sampled as 1 at edge N while channel i is IDLE, press_pulse[i] is high from edge N to edge N+1, and held[i] is 1 from edge N.
- Release follows the same pattern: the first edge that samples 0 produces release_pulse for the following cycle, and held drops at that same edge.
- long_pulse fires between (LONG_TICKS-1)·TICK_CNT_MAX+1 and LONG_TICKS·TICK_CNT_MAX+1 cycles after press_pulse. The exact value depends on the prescaler phase.
- Consecutive repeat_pulse events, and the gap from long_pulse to the first repeat_pulse, are exactly REPEAT_TICKS·TICK_CNT_MAX cycles apart.
- A one-cycle high input produces press_pulse, then release_pulse in the immediately following cycle.

## Test plan
All scenarios use WIDTH=2, TICK_CNT_MAX=4, LONG_TICKS=3, REPEAT_TICKS=2.
- **Reset:** hold rst = 1 for 3 cycles with in = 2'b11 → all outputs stay 0 during reset. press_pulse = 2'b11 for exactly one cycle after the first non-reset edge.
- **Short press:** in[0] high for 5 cycles → one press_pulse[0], then one release_pulse[0] 5 cycles later. long_pulse[0] = 0 and held[0] = 1 for exactly 5 cycles.
- **Long hold with repeats:** in[0] high for 40 cycles → long_pulse[0] exactly once, 9–13 cycles after press_pulse. repeat_pulse[0] then every 8 cycles, with no repeat after release_pulse[0].
- **Release on tick cycle:** align the fall of in[0] to the cycle where tick = 1 and hcnt = LONG_TICKS-1 → only release_pulse[0], no long_pulse[0].
- **Independent channels:** in[0] rises 2 cycles before in[1], both held 30 cycles → each channel's pulse sequence matches the single-channel reference model. Same-cycle pulses appear on both bits.
- **Reset mid-hold:** assert rst while in LONG → no release_pulse. held = 0 the cycle after rst, and press_pulse follows reset deassertion if in is still 1.
